// File: rtl/window_feeder_if.sv
// Window-feeder port bundle: pixel stream in, 3x3 window plus enable and status out.
// master = feeder side (drives windows), slave = pixel source / window consumer side.
interface window_feeder_if #(
  parameter int IMG_H = 10,
  parameter int DW    = 8
);
  logic [DW-1:0]            pix_in;
  logic                     pix_en;
  logic                     clear;
  logic [9*DW-1:0]          win_out;
  logic                     win_en;
  logic [$clog2(IMG_H)-1:0] row_cnt;
  logic                     frame_done;

  modport master (
    input  pix_in, pix_en, clear,
    output win_out, win_en, row_cnt, frame_done
  );

  modport slave (
    output pix_in, pix_en, clear,
    input  win_out, win_en, row_cnt, frame_done
  );
endinterface

// File: rtl/window_feeder.sv
// Forms stride-1 3x3 "valid" windows from a raster pixel stream via two line buffers; window valid 1 cycle after its last pixel.
// No backpressure: every accepted pixel (pix_en && !clear) is consumed, idle cycles hold state.
module window_feeder #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10,
  parameter int DW    = 8
) (
  input  logic           clk,
  input  logic           reset,
  window_feeder_if.master bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = 9 * DW;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] win_q, win_d;
  logic          win_en_q, win_en_d;
  logic          frame_done_q, frame_done_d;

  // A holds row r-1, B holds row r-2, both indexed by column.
  logic [DW-1:0] line_a_q [IMG_W];
  logic [DW-1:0] line_a_d [IMG_W];
  logic [DW-1:0] line_b_q [IMG_W];
  logic [DW-1:0] line_b_d [IMG_W];

  logic          accept;
  logic          last_col;
  logic          last_row;
  logic [DW-1:0] a_rd;
  logic [DW-1:0] b_rd;

  always_comb begin
    accept       = bus.pix_en && !bus.clear;
    last_col     = (col_q == CW'(IMG_W - 1));
    last_row     = (row_q == RW'(IMG_H - 1));
    a_rd         = line_a_q[col_q];
    b_rd         = line_b_q[col_q];

    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_en_d     = 1'b0;
    frame_done_d = 1'b0;
    line_a_d     = line_a_q;
    line_b_d     = line_b_q;

    if (bus.clear) begin
      col_d = '0;
      row_d = '0;
      win_d = '0;
    end else if (accept) begin
      line_b_d[col_q] = a_rd;
      line_a_d[col_q] = bus.pix_in;

      // Each row drops its left pixel; the new right column is {B, A, pixel}.
      win_d = {win_q[8*DW-1 -: 2*DW], b_rd,
               win_q[5*DW-1 -: 2*DW], a_rd,
               win_q[2*DW-1 : 0],     bus.pix_in};

      win_en_d     = (row_q >= RW'(2)) && (col_q >= CW'(2));
      frame_done_d = last_row && last_col;

      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_en_q     <= win_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers are refilled by the first two rows after any restart, so they need no reset.
  always_ff @(posedge clk) begin
    line_a_q <= line_a_d;
    line_b_q <= line_b_d;
  end

  assign bus.win_out    = win_q;
  assign bus.win_en     = win_en_q;
  assign bus.row_cnt    = row_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_feeder.sv
// Directed bench for window_feeder: a 4x4 instance for the short scenarios and a default 10x10 instance for back-to-back frames.
module tb_window_feeder;

  localparam logic [71:0] W0    = 72'h00_01_02_04_05_06_08_09_0A;
  localparam logic [71:0] W1    = 72'h01_02_03_05_06_07_09_0A_0B;
  localparam logic [71:0] W2    = 72'h04_05_06_08_09_0A_0C_0D_0E;
  localparam logic [71:0] W3    = 72'h05_06_07_09_0A_0B_0D_0E_0F;
  localparam logic [71:0] OFS10 = 72'h10_10_10_10_10_10_10_10_10;
  localparam logic [71:0] B_F1_FIRST = 72'h00_01_02_0A_0B_0C_14_15_16;
  localparam logic [71:0] B_F1_LAST  = 72'h4D_4E_4F_57_58_59_61_62_63;
  localparam logic [71:0] B_F2_FIRST = 72'hFF_FE_FD_F5_F4_F3_EB_EA_E9;
  localparam logic [71:0] B_F2_LAST  = 72'hB2_B1_B0_A8_A7_A6_9E_9D_9C;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_feeder_if #(.IMG_H(4),  .DW(8)) s_if ();
  window_feeder_if #(.IMG_H(10), .DW(8)) b_if ();

  window_feeder #(.IMG_W(4), .IMG_H(4), .DW(8)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.master)
  );

  window_feeder #(.IMG_W(10), .IMG_H(10), .DW(8)) u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Window monitors: capture every window and flag latency / pulse-shape violations.
  logic [71:0] sq_win[$];
  bit          sq_fd[$];
  logic [71:0] bq_win[$];
  bit          bq_fd[$];
  bit          s_prev_acc, b_prev_acc, s_last_en, b_last_en;
  logic [7:0]  s_prev_pix, b_prev_pix;
  int          s_lat_err = 0, s_consec = 0, s_orphan = 0;
  int          b_lat_err = 0, b_orphan = 0;

  always @(posedge clk) begin
    s_prev_acc <= s_if.pix_en && !s_if.clear;
    s_prev_pix <= s_if.pix_in;
    b_prev_acc <= b_if.pix_en && !b_if.clear;
    b_prev_pix <= b_if.pix_in;
  end

  always @(negedge clk) begin
    if (s_if.win_en === 1'b1) begin
      sq_win.push_back(s_if.win_out);
      sq_fd.push_back(s_if.frame_done);
      if (!s_prev_acc || s_prev_pix !== s_if.win_out[7:0]) s_lat_err++;
      if (s_last_en) s_consec++;
    end
    if (s_if.frame_done === 1'b1 && s_if.win_en !== 1'b1) s_orphan++;
    s_last_en = (s_if.win_en === 1'b1);

    if (b_if.win_en === 1'b1) begin
      bq_win.push_back(b_if.win_out);
      bq_fd.push_back(b_if.frame_done);
      if (!b_prev_acc || b_prev_pix !== b_if.win_out[7:0]) b_lat_err++;
    end
    if (b_if.frame_done === 1'b1 && b_if.win_en !== 1'b1) b_orphan++;
    b_last_en = (b_if.win_en === 1'b1);
  end

  task automatic s_drive(input logic [7:0] v, input logic en, input logic clr);
    s_if.pix_in = v;
    s_if.pix_en = en;
    s_if.clear  = clr;
    @(posedge clk);
    #1;
    s_if.pix_en = 1'b0;
    s_if.clear  = 1'b0;
  endtask

  task automatic b_drive(input logic [7:0] v);
    b_if.pix_in = v;
    b_if.pix_en = 1'b1;
    @(posedge clk);
    #1;
    b_if.pix_en = 1'b0;
  endtask

  task automatic s_frame(input logic [7:0] base, input int gap);
    for (int i = 0; i < 16; i++) begin
      s_drive(base + 8'(i), 1'b1, 1'b0);
      repeat (gap) s_drive(8'h00, 1'b0, 1'b0);
    end
    repeat (4) s_drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic s_check_frame(input string tag, input logic [71:0] ofs);
    check({tag, "_count"}, 72'(sq_win.size()), 72'd4);
    if (sq_win.size() == 4) begin
      check({tag, "_w0"}, sq_win[0], W0 + ofs);
      check({tag, "_w1"}, sq_win[1], W1 + ofs);
      check({tag, "_w2"}, sq_win[2], W2 + ofs);
      check({tag, "_w3"}, sq_win[3], W3 + ofs);
      check({tag, "_fd"}, 72'({sq_fd[0], sq_fd[1], sq_fd[2], sq_fd[3]}), 72'b0001);
    end
    check({tag, "_latency"}, 72'(s_lat_err), 72'd0);
    check({tag, "_orphan_fd"}, 72'(s_orphan), 72'd0);
    sq_win.delete();
    sq_fd.delete();
  endtask

  initial begin
    int c0;
    reset       = 1'b1;
    s_if.pix_in = '0;
    s_if.pix_en = 1'b0;
    s_if.clear  = 1'b0;
    b_if.pix_in = '0;
    b_if.pix_en = 1'b0;
    b_if.clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_win_out", s_if.win_out, 72'h0);
    check("rst_win_en", 72'(s_if.win_en), 72'd0);
    check("rst_frame_done", 72'(s_if.frame_done), 72'd0);
    check("rst_row_cnt", 72'(s_if.row_cnt), 72'd0);
    check("rst_big_row_cnt", 72'(b_if.row_cnt), 72'd0);
    reset = 1'b0;
    s_drive(8'h00, 1'b0, 1'b0);

    // Continuous 4x4 frame.
    c0 = s_consec;
    s_frame(8'h00, 0);
    check("cont_back_to_back", 72'(s_consec - c0), 72'd2);
    s_check_frame("cont", 72'h0);

    // pix_en every third cycle.
    c0 = s_consec;
    s_frame(8'h00, 2);
    check("sparse_no_consec", 72'(s_consec - c0), 72'd0);
    s_check_frame("sparse", 72'h0);

    // Reset mid-frame after pixel 0x09, then a fresh frame.
    for (int i = 0; i < 10; i++) s_drive(8'(i), 1'b1, 1'b0);
    check("mid_row_cnt", 72'(s_if.row_cnt), 72'd2);
    check("mid_no_win", 72'(sq_win.size()), 72'd0);
    reset = 1'b1;
    #2;
    check("async_rst_win_out", s_if.win_out, 72'h0);
    check("async_rst_row_cnt", 72'(s_if.row_cnt), 72'd0);
    check("async_rst_win_en", 72'(s_if.win_en), 72'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    s_frame(8'h10, 0);
    s_check_frame("after_rst", OFS10);

    // clear presented together with pixel 0x0A.
    for (int i = 0; i < 10; i++) s_drive(8'(i), 1'b1, 1'b0);
    s_drive(8'h0A, 1'b1, 1'b1);
    check("clr_row_cnt", 72'(s_if.row_cnt), 72'd0);
    check("clr_win_en", 72'(s_if.win_en), 72'd0);
    check("clr_win_out", s_if.win_out, 72'h0);
    check("clr_frame_done", 72'(s_if.frame_done), 72'd0);
    repeat (2) s_drive(8'h00, 1'b0, 1'b0);
    check("clr_dropped", 72'(sq_win.size()), 72'd0);
    s_frame(8'h00, 0);
    s_check_frame("after_clr", 72'h0);

    // Default 10x10: ramp frame then 0xFF-ramp frame, no gap.
    for (int i = 0; i < 100; i++) b_drive(8'(i));
    for (int i = 0; i < 100; i++) b_drive(8'hFF - 8'(i));
    repeat (4) @(posedge clk);
    #1;
    check("big_count", 72'(bq_win.size()), 72'd128);
    if (bq_win.size() == 128) begin
      int nfd;
      nfd = 0;
      foreach (bq_fd[i]) if (bq_fd[i]) nfd++;
      check("big_fd_total", 72'(nfd), 72'd2);
      check("big_fd_f1", 72'(bq_fd[63]), 72'd1);
      check("big_fd_f2", 72'(bq_fd[127]), 72'd1);
      check("big_f1_first", bq_win[0], B_F1_FIRST);
      check("big_f1_last", bq_win[63], B_F1_LAST);
      check("big_f2_first", bq_win[64], B_F2_FIRST);
      check("big_f2_last", bq_win[127], B_F2_LAST);
    end
    check("big_latency", 72'(b_lat_err), 72'd0);
    check("big_orphan_fd", 72'(b_orphan), 72'd0);
    check("big_row_cnt_end", 72'(b_if.row_cnt), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
